bram_stream_reader: RTL
=======================

# bram_stream_reader

Streaming read engine for the dual-port `bram_dp` buffers: on `start` it drains `len` consecutive words from the RAM read port, beginning at `base_addr`, and presents them on a valid/ready stream. It drives `en`/`addrR` of a `bram_dp` instance and absorbs the RAM's one-cycle synchronous read latency with a 2-entry output buffer, so downstream back-pressure never loses data. It sits between AFU scratch RAMs and the classification datapath consumers.

## Interface
- `DATA_WIDTH`, 32, word width; matches the attached `bram_dp`.
- `ADDR_WIDTH_RAM`, 7, RAM address width; RAM depth is 2^ADDR_WIDTH_RAM.

- `clk`  in  1  single clock; all logic is rising-edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  start request; sampled only in IDLE.
- `base_addr`  in  ADDR_WIDTH_RAM  first read address; captured on accepted `start`.
- `len`  in  ADDR_WIDTH_RAM+1  word count, 0..2^ADDR_WIDTH_RAM; captured on accepted `start`.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse when the transfer completes.
- `ram_en`  out  1  to `bram_dp.en`.
- `ram_addr`  out  ADDR_WIDTH_RAM  to `bram_dp.addrR`.
- `ram_dout`  in  DATA_WIDTH  from `bram_dp.dout`; valid one cycle after `ram_en`.
- `m_data`  out  DATA_WIDTH  stream data (buffer head).
- `m_valid`  out  1  stream valid.
- `m_ready`  in  1  stream ready; transfer on `m_valid & m_ready`.

## Operation
- States:
  - IDLE: `start` -> READ. If `len==0`, go to IDLE and pulse `done` next cycle; no RAM access occurs.
  - READ: issue reads until `remaining==0` -> DRAIN.
  - DRAIN: wait until the buffer is empty and no read is in flight, pulse `done` -> IDLE.
- Counters:
  - `remaining` (ADDR_WIDTH_RAM+1 bits) is loaded with `len` and decrements on each issued read.
  - `rd_ptr` is loaded with `base_addr` and increments per issue. It wraps modulo 2^ADDR_WIDTH_RAM, e.g. base 0x7E, len 4 reads 0x7E, 0x7F, 0x00, 0x01.
- Issue rule: `ram_en=1` in READ when `remaining>0` and either:
  - `(count + inflight) <= 1`, or
  - `(count + inflight) == 2` and a pop happens this cycle.
  
  Here `count` is the buffer occupancy (0..2) and `inflight` is the registered `ram_en` from the previous cycle. The buffer therefore never overflows.
- Capture: when `inflight==1`, `ram_dout` is written into the buffer at that edge. A simultaneous push and pop keeps `count` unchanged.
- Data order on `m_data` is strictly address order.
- `start` while `busy` is ignored. `base_addr` and `len` may change freely after capture.
- `m_data` holds stable while `m_valid & !m_ready`.

## Timing
- Reset values: `busy=0`, `done=0`, `ram_en=0`, `ram_addr=0`, `m_valid=0`, `m_data=0`; state IDLE, buffer empty, `inflight=0`.
- `start` accepted at edge T:
  - `busy=1` and first `ram_en`/`ram_addr=base_addr` in cycle T+1.
  - Data captured at the end of T+2; `m_valid=1` in T+3.
  - First-word latency is 3 cycles.
- With `m_ready` held high: one word per cycle; an N-word transfer ends with the last pop in cycle T+N+2.
- `done` pulses in the cycle after the last pop. `busy` falls in that same cycle. A new `start` is accepted in the `done` cycle.
- `len==0`: `done` in T+1, `busy` stays 0, `ram_en` never asserts.
- If `m_ready` is deasserted, issue stalls within one cycle and the buffer holds at most 2 words. Resuming `m_ready` yields back-to-back words with no bubble.
- `rst_n` low mid-transfer immediately forces the reset values and flushes the buffer and in-flight read. The `ram_dout` that follows is discarded.

## Configuration
- `BRAM_STREAM_LAST_EN`:
  - When defined, adds output `m_last` (1 bit, reset 0). `m_last` is high with `m_valid` on the final word of a transfer; a 1-bit tag is stored per buffer entry.
  - When undefined, there is no `m_last` port or tag storage. All other behaviour is identical.

## Test plan
- RAM preloaded with addr-as-data, base 0x10, len 8, `m_ready=1` -> words 0x10..0x17 in cycles T+3..T+10; `done` at T+11; `ram_en` high exactly 8 cycles.
- Wrap: base 0x7E, len 4 -> `m_data` sequence 0x7E, 0x7F, 0x00, 0x01.
- Back-pressure: len 16, `m_ready` random 50% -> all 16 words in order, none duplicated; `count` never exceeds 2; `m_data` stable while stalled.
- `len=0` -> `done` at T+1, no `ram_en`, `m_valid` stays 0. `start` pulsed while busy -> ignored, the first transfer completes unchanged.
- Reset: assert `rst_n=0` after 3 of 10 words -> all outputs are at reset values the same cycle. A new start with base 0, len 2 then returns exactly 2 words.
- Full depth: base 0, len 128 -> 128 words, `done` once; with `BRAM_STREAM_LAST_EN`, `m_last=1` only on word 127.

Source files
------------

// File: rtl/bram_stream_reader_if.sv
// Bundle of control, RAM read-port and output-stream signals for bram_stream_reader.
// The m_last signal exists only when BRAM_STREAM_LAST_EN is defined.
interface bram_stream_reader_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH_RAM = 7
);
    // Transfer control
    logic                      start;
    logic [ADDR_WIDTH_RAM-1:0] base_addr;
    logic [ADDR_WIDTH_RAM:0]   len;
    logic                      busy;
    logic                      done;

    // bram_dp read port
    logic                      ram_en;
    logic [ADDR_WIDTH_RAM-1:0] ram_addr;
    logic [DATA_WIDTH-1:0]     ram_dout;

    // Output stream
    logic [DATA_WIDTH-1:0]     m_data;
    logic                      m_valid;
    logic                      m_ready;
`ifdef BRAM_STREAM_LAST_EN
    logic                      m_last;
`endif

    modport master (
        input  start, base_addr, len, ram_dout, m_ready,
`ifdef BRAM_STREAM_LAST_EN
        output m_last,
`endif
        output busy, done, ram_en, ram_addr, m_data, m_valid
    );

    modport slave (
        output start, base_addr, len, ram_dout, m_ready,
`ifdef BRAM_STREAM_LAST_EN
        input  m_last,
`endif
        input  busy, done, ram_en, ram_addr, m_data, m_valid
    );
endinterface

// File: rtl/bram_stream_reader.sv
// Drains len consecutive bram_dp words from base_addr onto a valid/ready stream,
// hiding the one-cycle RAM read latency behind a 2-entry buffer. Define BRAM_STREAM_LAST_EN for m_last.
module bram_stream_reader #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH_RAM = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bram_stream_reader_if.master bus
);

    localparam int CW = ADDR_WIDTH_RAM + 1;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } state_e;

    state_e                    state_q;
    logic [CW-1:0]             remaining_q;
    logic [ADDR_WIDTH_RAM-1:0] rd_ptr_q;
    logic                      inflight_q;
    logic                      busy_q;
    logic                      done_q;

    logic [DATA_WIDTH-1:0]     buf_q [2];
    logic                      wr_idx_q;
    logic                      rd_idx_q;
    logic [1:0]                count_q;
    logic [1:0]                count_d;

    logic                      push;
    logic                      pop;
    logic                      issue;
    logic                      last_issue;
    logic [1:0]                occupancy;

    // occupancy counts words already buffered plus the one on its way from the RAM;
    // the second clause lets a pop free the slot the new read will land in.
    always_comb begin
        push       = inflight_q;
        pop        = (count_q != 2'd0) && bus.m_ready;
        occupancy  = count_q + 2'(inflight_q);
        issue      = (state_q == READ) && (remaining_q != '0) &&
                     ((occupancy <= 2'd1) || ((occupancy == 2'd2) && pop));
        last_issue = issue && (remaining_q == CW'(1));
        count_d    = count_q + 2'(push) - 2'(pop);
    end

    assign bus.ram_en   = issue;
    assign bus.ram_addr = rd_ptr_q;
    assign bus.m_valid  = (count_q != 2'd0);
    assign bus.m_data   = buf_q[rd_idx_q];
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

    // NOTE: every always_ff uses non-blocking assignments so all registers update
    // together from the values seen before the edge, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            rd_ptr_q    <= '0;
            inflight_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            inflight_q <= issue;
            done_q     <= 1'b0;

            if (issue) begin
                remaining_q <= remaining_q - CW'(1);
                rd_ptr_q    <= rd_ptr_q + ADDR_WIDTH_RAM'(1);
            end

            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.len == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q     <= READ;
                            busy_q      <= 1'b1;
                            remaining_q <= bus.len;
                            rd_ptr_q    <= bus.base_addr;
                        end
                    end
                end
                READ: begin
                    if (last_issue || (remaining_q == '0)) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Finish on the edge of the final pop so done lands one cycle later.
                    if ((count_d == 2'd0) && !inflight_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // NOTE: the two buffer entries are reset so m_data reads zero out of reset; this is
    // cheap for two flops-wide words but would not be done for a real RAM array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                buf_q[i] <= '0;
            end
            wr_idx_q <= 1'b0;
            rd_idx_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                buf_q[wr_idx_q] <= bus.ram_dout;
                wr_idx_q        <= ~wr_idx_q;
            end
            if (pop) begin
                rd_idx_q <= ~rd_idx_q;
            end
            count_q <= count_d;
        end
    end

`ifdef BRAM_STREAM_LAST_EN
    // The last-word tag travels with the read so it stays aligned under back-pressure.
    logic       inflight_last_q;
    logic [1:0] tag_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_last_q <= 1'b0;
            tag_q           <= 2'b00;
        end else begin
            inflight_last_q <= last_issue;
            if (push) begin
                tag_q[wr_idx_q] <= inflight_last_q;
            end
        end
    end

    assign bus.m_last = bus.m_valid && tag_q[rd_idx_q];
`endif

endmodule
